// File: rtl/data_frame_tx.sv
// Serial frame transmitter: a small word FIFO feeds a preamble / data / gap
// framer. Words go out MSB first at one bit per clock.
module data_frame_tx #(
    parameter int PRE_LEN     = 10,
    parameter int FRAME_WORDS = 720,
    parameter int GAP_LEN     = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int START_LEVEL = 4
) (
    input  logic       CLK_30MHz,
    input  logic       RST,
    input  logic       WR_VALID,
    input  logic [9:0] WR_DATA,
    output logic       WR_READY,
    input  logic       CLR_ERR,
    output logic       DOUT,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       UNDERRUN
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] START_C   = CW'(START_LEVEL);
    localparam logic [4:0]    PRE_LAST  = 5'(PRE_LEN - 1);
    localparam logic [4:0]    GAP_LAST  = 5'(GAP_LEN - 1);
    localparam logic [4:0]    BIT_LAST  = 5'd9;
    localparam logic [9:0]    WORD_LAST = 10'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // FIFO storage and pointers
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, fifo_empty;
    logic [9:0]    head;

    // Framer state
    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [9:0] word_q, word_d;
    logic [9:0] shift_q, shift_d;
    logic       dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       under_q, under_d;
    logic       pop_req, under_ev;

    assign WR_READY   = (count_q != DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push       = WR_VALID & WR_READY;
    assign pop        = pop_req & ~fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    assign DOUT       = dout_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign UNDERRUN   = under_q;

    // FIFO pointer and occupancy update; push and pop together leave occupancy unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Framer next-state: one state per output bit, word fetched on the last bit of the previous slot
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        shift_d  = shift_q;
        pop_req  = 1'b0;
        under_ev = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q >= START_C) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    pop_req = 1'b1;
                    state_d = S_DATA;
                    cnt_d   = '0;
                    word_d  = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DATA: begin
                shift_d = {shift_q[8:0], 1'b0};
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = S_GAP;
                    end else begin
                        pop_req = 1'b1;
                        word_d  = word_q + 10'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An empty FIFO at fetch time sends a zero word so the frame keeps its length
        if (pop_req) begin
            if (fifo_empty) begin
                shift_d  = '0;
                under_ev = 1'b1;
            end else begin
                shift_d = head;
            end
        end
        under_d = under_ev | (under_q & ~CLR_ERR);
        dout_d  = (state_d == S_PRE) | ((state_d == S_DATA) & shift_d[9]);
        busy_d  = (state_d != S_IDLE);
    end

    // FIFO word storage
    always_ff @(posedge CLK_30MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    // Control registers with synchronous reset; the shift register carries data only
    always_ff @(posedge CLK_30MHz) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            under_q  <= under_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_data_frame_tx.sv
// Testbench for data_frame_tx: a feeder pushes words and records accepted ones
// in a scoreboard queue; a frame capture pops expected words at fetch points.
`timescale 1ns/1ps
module tb_data_frame_tx;

    localparam int PRE   = 10;
    localparam int W     = 720;
    localparam int GAP   = 16;
    localparam int TOTAL = PRE + 10 * W + GAP;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [9:0] wr_data;
    logic       wr_ready;
    logic       clr_err;
    logic       dout;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    always #16.667 clk = ~clk;

    data_frame_tx #(
        .PRE_LEN(PRE), .FRAME_WORDS(W), .GAP_LEN(GAP), .FIFO_DEPTH(8), .START_LEVEL(4)
    ) dut (
        .CLK_30MHz (clk),
        .RST       (rst),
        .WR_VALID  (wr_valid),
        .WR_DATA   (wr_data),
        .WR_READY  (wr_ready),
        .CLR_ERR   (clr_err),
        .DOUT      (dout),
        .BUSY      (busy),
        .FRAME_DONE(frame_done),
        .UNDERRUN  (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] feed_q[$];
    logic [9:0] exp_q[$];
    int         feed_pct = 100;

    bit         cap_dout [0:TOTAL];
    bit         cap_busy [0:TOTAL];
    bit         cap_fd   [0:TOTAL];
    bit         cap_ur   [0:TOTAL];
    bit         cap_rdy  [0:TOTAL];
    logic [9:0] exp_w    [W];
    int         first_under;
    bit         started;
    int         clr_a = -1;
    int         clr_b = -1;

    // Feeder: presents queued words, records each accepted word in the scoreboard
    initial begin : feeder
        bit acc;
        wr_valid = 1'b0;
        wr_data  = '0;
        forever begin
            @(negedge clk);
            acc = wr_valid && wr_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(wr_data);
                if (feed_q.size() > 0) feed_q.delete(0);
            end
            if (feed_q.size() > 0 && $urandom_range(0, 99) < feed_pct) begin
                wr_valid = 1'b1;
                wr_data  = feed_q[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    // Frame capture: n=0 is the first cycle with DOUT high; word k is fetched at the edge after n=PRE+10k-1
    task automatic capture(input int max_wait, input int stop_n);
        int k;
        started     = 1'b0;
        first_under = -1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (dout) begin
                started = 1'b1;
                break;
            end
        end
        if (!started) return;
        for (int n = 0; n <= stop_n; n++) begin
            if (n > 0) @(negedge clk);
            clr_err     = (n == clr_a) || (n == clr_b);
            cap_dout[n] = dout;
            cap_busy[n] = busy;
            cap_fd[n]   = frame_done;
            cap_ur[n]   = underrun;
            cap_rdy[n]  = wr_ready;
            if (n + 1 >= PRE && (n + 1 - PRE) % 10 == 0 && (n + 1 - PRE) / 10 < W) begin
                k = (n + 1 - PRE) / 10;
                if (exp_q.size() > 0) begin
                    exp_w[k] = exp_q.pop_front();
                end else begin
                    exp_w[k] = '0;
                    if (first_under < 0) first_under = k;
                end
            end
        end
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL reset_dout: got %b want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    endtask

    // Frame 1 carries w[i]=i; frame 2's words are queued behind it so the FIFO stays loaded
    task automatic test_stream;
        logic [9:0] g;
        int s;
        feed_pct = 100;
        for (int i = 0; i < W; i++) feed_q.push_back(10'(i));
        for (int i = 0; i < W; i++) feed_q.push_back(10'($urandom));
        capture(50, TOTAL);
        n_cmp++; if (started !== 1'b1) begin n_bad++; $display("FAIL stream_start: got %b want 1", started); end
        if (!started) return;
        // FIFO fills during the preamble (5 words at n=0), pop at n=PRE frees one slot
        n_cmp++; if (cap_rdy[2] !== 1'b1) begin n_bad++; $display("FAIL stream_ready_n2: got %b want 1", cap_rdy[2]); end
        n_cmp++; if (cap_rdy[3] !== 1'b0) begin n_bad++; $display("FAIL stream_ready_full: got %b want 0", cap_rdy[3]); end
        n_cmp++; if (cap_rdy[PRE] !== 1'b1) begin n_bad++; $display("FAIL stream_ready_after_pop: got %b want 1", cap_rdy[PRE]); end
        n_cmp++; if (cap_rdy[PRE+1] !== 1'b0) begin n_bad++; $display("FAIL stream_ready_refull: got %b want 0", cap_rdy[PRE+1]); end
        s = 0;
        for (int i = 0; i < PRE; i++) if (cap_dout[i]) s++;
        n_cmp++; if (s != PRE) begin n_bad++; $display("FAIL stream_preamble_ones: got %0d want %0d", s, PRE); end
        n_cmp++; if (cap_busy[0] !== 1'b1) begin n_bad++; $display("FAIL stream_busy_pre: got %b want 1", cap_busy[0]); end
        for (int k = 0; k < W; k++) begin
            for (int b = 0; b < 10; b++) g[9-b] = cap_dout[PRE+10*k+b];
            n_cmp++; if (g !== exp_w[k]) begin n_bad++; $display("FAIL stream_word[%0d]: got %03h want %03h", k, g, exp_w[k]); end
        end
        s = 0;
        for (int i = PRE + 10 * W; i < TOTAL; i++) if (!cap_dout[i] && cap_busy[i]) s++;
        n_cmp++; if (s != GAP) begin n_bad++; $display("FAIL stream_gap_zeros: got %0d want %0d", s, GAP); end
        s = 0;
        for (int i = 0; i < TOTAL; i++) if (cap_fd[i]) s++;
        n_cmp++; if (s != 0) begin n_bad++; $display("FAIL stream_early_done: got %0d pulses want 0", s); end
        n_cmp++; if (cap_fd[TOTAL] !== 1'b1) begin n_bad++; $display("FAIL stream_done_at_7226: got %b want 1", cap_fd[TOTAL]); end
        n_cmp++; if (cap_busy[TOTAL] !== 1'b0) begin n_bad++; $display("FAIL stream_busy_idle: got %b want 0", cap_busy[TOTAL]); end
        n_cmp++; if (cap_ur[TOTAL] !== 1'b0) begin n_bad++; $display("FAIL stream_underrun: got %b want 0", cap_ur[TOTAL]); end
    endtask

    // Next preamble must appear the cycle right after FRAME_DONE; throttled feed mixes push and pop
    task automatic test_back_to_back;
        logic [9:0] g;
        feed_pct = 40;
        capture(1, TOTAL);
        n_cmp++; if (started !== 1'b1) begin n_bad++; $display("FAIL b2b_preamble_next_cycle: got %b want 1", started); end
        if (!started) return;
        for (int k = 0; k < W; k++) begin
            for (int b = 0; b < 10; b++) g[9-b] = cap_dout[PRE+10*k+b];
            n_cmp++; if (g !== exp_w[k]) begin n_bad++; $display("FAIL b2b_word[%0d]: got %03h want %03h", k, g, exp_w[k]); end
        end
        n_cmp++; if (cap_fd[TOTAL] !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", cap_fd[TOTAL]); end
        n_cmp++; if (cap_ur[TOTAL] !== (first_under >= 0)) begin n_bad++; $display("FAIL b2b_underrun: got %b want %b", cap_ur[TOTAL], first_under >= 0); end
    endtask

    task automatic test_underrun;
        logic [9:0] g;
        int s;
        feed_pct = 100;
        for (int i = 0; i < 4; i++) feed_q.push_back(10'($urandom_range(1, 1023)));
        clr_a = PRE + 54;
        clr_b = PRE + 69;
        capture(50, TOTAL);
        clr_a = -1;
        clr_b = -1;
        n_cmp++; if (started !== 1'b1) begin n_bad++; $display("FAIL under_start: got %b want 1", started); end
        if (!started) return;
        for (int k = 0; k < W; k++) begin
            for (int b = 0; b < 10; b++) g[9-b] = cap_dout[PRE+10*k+b];
            n_cmp++; if (g !== exp_w[k]) begin n_bad++; $display("FAIL under_word[%0d]: got %03h want %03h", k, g, exp_w[k]); end
        end
        n_cmp++; if (cap_ur[PRE+39] !== 1'b0) begin n_bad++; $display("FAIL under_before_event: got %b want 0", cap_ur[PRE+39]); end
        n_cmp++; if (cap_ur[PRE+40] !== 1'b1) begin n_bad++; $display("FAIL under_set_word4: got %b want 1", cap_ur[PRE+40]); end
        n_cmp++; if (cap_ur[PRE+55] !== 1'b0) begin n_bad++; $display("FAIL under_clr_mid: got %b want 0", cap_ur[PRE+55]); end
        n_cmp++; if (cap_ur[PRE+60] !== 1'b1) begin n_bad++; $display("FAIL under_reset_word6: got %b want 1", cap_ur[PRE+60]); end
        n_cmp++; if (cap_ur[PRE+70] !== 1'b1) begin n_bad++; $display("FAIL under_set_wins: got %b want 1", cap_ur[PRE+70]); end
        s = 0;
        for (int i = 0; i < TOTAL; i++) if (cap_fd[i]) s++;
        n_cmp++; if (s != 0) begin n_bad++; $display("FAIL under_early_done: got %0d pulses want 0", s); end
        n_cmp++; if (cap_fd[TOTAL] !== 1'b1) begin n_bad++; $display("FAIL under_done_at_7226: got %b want 1", cap_fd[TOTAL]); end
        n_cmp++; if (cap_ur[TOTAL] !== 1'b1) begin n_bad++; $display("FAIL under_sticky_end: got %b want 1", cap_ur[TOTAL]); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL under_clr_err: got %b want 0", underrun); end
        @(negedge clk);
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL under_stays_clear: got %b want 0", underrun); end
    endtask

    task automatic test_reset_midframe;
        logic [9:0] g;
        int s;
        feed_pct = 100;
        for (int i = 0; i < 400; i++) feed_q.push_back(10'($urandom));
        capture(50, PRE + 3000);
        n_cmp++; if (started !== 1'b1) begin n_bad++; $display("FAIL rstmid_start: got %b want 1", started); end
        if (!started) return;
        for (int k = 0; k < 300; k++) begin
            for (int b = 0; b < 10; b++) g[9-b] = cap_dout[PRE+10*k+b];
            n_cmp++; if (g !== exp_w[k]) begin n_bad++; $display("FAIL rstmid_word[%0d]: got %03h want %03h", k, g, exp_w[k]); end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        feed_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL rstmid_dout: got %b want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_wr_ready: got %b want 1", wr_ready); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rstmid_underrun: got %b want 0", underrun); end
        for (int i = 0; i < 4; i++) feed_q.push_back(10'($urandom));
        capture(50, PRE + 40);
        n_cmp++; if (started !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart: got %b want 1", started); end
        if (!started) return;
        s = 0;
        for (int i = 0; i < PRE; i++) if (cap_dout[i]) s++;
        n_cmp++; if (s != PRE) begin n_bad++; $display("FAIL rstmid_preamble: got %0d want %0d", s, PRE); end
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 10; b++) g[9-b] = cap_dout[PRE+10*k+b];
            n_cmp++; if (g !== exp_w[k]) begin n_bad++; $display("FAIL rstmid_new_word[%0d]: got %03h want %03h", k, g, exp_w[k]); end
        end
    endtask

    initial begin : watchdog
        #(33.334 * 60000);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst     = 1'b1;
        clr_err = 1'b0;
        test_reset();
        test_stream();
        test_back_to_back();
        test_underrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
